// File: rtl/risc_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : risc_pipe_hazard_ctrl
// Description : Hazard and forwarding controller for the 4-stage RISC
//               pipeline (IF, DOF, EX, WB). Tracks EX/WB destination
//               metadata, detects RAW hazards on the DOF source operands
//               and resolves them by forwarding, stall+bubble, or flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc_pipe_hazard_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dof_valid,
    input  logic [ADDR_W-1:0] dof_aa,
    input  logic [ADDR_W-1:0] dof_ba,
    input  logic              dof_use_a,
    input  logic              dof_use_b,
    input  logic              dof_rw,
    input  logic [ADDR_W-1:0] dof_da,
    input  logic              dof_load,
    input  logic              ex_branch_taken,
    input  logic [DATA_W-1:0] dof_bus_a,
    input  logic [DATA_W-1:0] dof_bus_b,
    input  logic [DATA_W-1:0] ex_f,
    input  logic [DATA_W-1:0] wb_d,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              flush_dof,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [DATA_W-1:0] fwd_bus_a,
    output logic [DATA_W-1:0] fwd_bus_b,
    output logic              ex_valid,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] c_SEL_RF = 2'd0;
    localparam logic [1:0] c_SEL_EX = 2'd1;
    localparam logic [1:0] c_SEL_WB = 2'd2;

    // Destination metadata of the instructions currently in EX and WB
    logic              r_ex_valid, r_ex_rw, r_ex_load;
    logic [ADDR_W-1:0] r_ex_da;
    logic              r_wb_valid, r_wb_rw, r_wb_load;
    logic [ADDR_W-1:0] r_wb_da;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_ex_hit_a, w_ex_hit_b, w_wb_hit_a, w_wb_hit_b;
    logic              w_hazard;
    logic [1:0]        w_sel_a, w_sel_b;
    logic              w_stall, w_bubble;

    // Source match against EX and WB; R0 is hardwired zero and never matches
    always_comb begin
        w_ex_hit_a = dof_use_a && (dof_aa != '0) && r_ex_valid && r_ex_rw && (r_ex_da == dof_aa);
        w_ex_hit_b = dof_use_b && (dof_ba != '0) && r_ex_valid && r_ex_rw && (r_ex_da == dof_ba);
        w_wb_hit_a = dof_use_a && (dof_aa != '0) && r_wb_valid && r_wb_rw && (r_wb_da == dof_aa);
        w_wb_hit_b = dof_use_b && (dof_ba != '0) && r_wb_valid && r_wb_rw && (r_wb_da == dof_ba);
    end

    generate
        if (FWD_EN != 0) begin : g_fwd
            // Forwarding: EX has priority over WB; a load in EX cannot forward yet
            always_comb begin
                w_hazard = 1'b0;
                w_sel_a  = c_SEL_RF;
                w_sel_b  = c_SEL_RF;
                if (dof_valid) begin
                    w_hazard = (w_ex_hit_a || w_ex_hit_b) && r_ex_load;
                    if (w_ex_hit_a) begin
                        w_sel_a = r_ex_load ? c_SEL_RF : c_SEL_EX;
                    end else if (w_wb_hit_a) begin
                        w_sel_a = c_SEL_WB;
                    end
                    if (w_ex_hit_b) begin
                        w_sel_b = r_ex_load ? c_SEL_RF : c_SEL_EX;
                    end else if (w_wb_hit_b) begin
                        w_sel_b = c_SEL_WB;
                    end
                end
            end
        end else begin : g_stall_only
            // No forwarding: any outstanding write to a source stalls DOF
            always_comb begin
                w_hazard = 1'b0;
                w_sel_a  = c_SEL_RF;
                w_sel_b  = c_SEL_RF;
                if (dof_valid) begin
                    w_hazard = w_ex_hit_a || w_ex_hit_b || w_wb_hit_a || w_wb_hit_b;
                end
            end
        end
    endgenerate

    // A taken branch overrides any stall: DOF is squashed, EX gets a bubble
    always_comb begin
        w_stall  = w_hazard && !ex_branch_taken;
        w_bubble = w_hazard || ex_branch_taken;
    end

    // Operand forwarding muxes; encoding 3 falls back to register-file data
    always_comb begin
        case (w_sel_a)
            c_SEL_EX: fwd_bus_a = ex_f;
            c_SEL_WB: fwd_bus_a = wb_d;
            default:  fwd_bus_a = dof_bus_a;
        endcase
        case (w_sel_b)
            c_SEL_EX: fwd_bus_b = ex_f;
            c_SEL_WB: fwd_bus_b = wb_d;
            default:  fwd_bus_b = dof_bus_b;
        endcase
    end

    // Stage metadata advance and stall counting on the pipeline's falling edge
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_rw     <= 1'b0;
            r_ex_da     <= '0;
            r_ex_load   <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rw     <= 1'b0;
            r_wb_da     <= '0;
            r_wb_load   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_bubble || !dof_valid) begin
                r_ex_valid <= 1'b0;
                r_ex_rw    <= 1'b0;
                r_ex_da    <= '0;
                r_ex_load  <= 1'b0;
            end else begin
                r_ex_valid <= 1'b1;
                r_ex_rw    <= dof_rw;
                r_ex_da    <= dof_da;
                r_ex_load  <= dof_load;
            end
            r_wb_valid <= r_ex_valid;
            r_wb_rw    <= r_ex_rw;
            r_wb_da    <= r_ex_da;
            r_wb_load  <= r_ex_load;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall_if  = w_stall;
    assign bubble_ex = w_bubble;
    assign flush_dof = ex_branch_taken;
    assign fwd_a_sel = w_sel_a;
    assign fwd_b_sel = w_sel_b;
    assign ex_valid  = r_ex_valid;
    assign wb_valid  = r_wb_valid;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_risc_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_risc_pipe_hazard_ctrl
// Description : Scoreboard bench for risc_pipe_hazard_ctrl. One instance with
//               forwarding (CNT_W=16), one stall-only instance (CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_risc_pipe_hazard_ctrl;

    localparam logic [31:0] c_BUS_A = 32'hAAAA_0001;
    localparam logic [31:0] c_BUS_B = 32'hBBBB_0002;
    localparam logic [31:0] c_EX_F  = 32'h0000_0011;
    localparam logic [31:0] c_WB_D  = 32'hDEAD_BEEF;

    typedef struct packed {
        logic       valid;
        logic [4:0] aa;
        logic [4:0] ba;
        logic       ua;
        logic       ub;
        logic       rw;
        logic [4:0] da;
        logic       load;
        logic       br;
    } instr_t;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        flush;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic        exv;
        logic        wbv;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        r_reset;
    logic        r_valid, r_ua, r_ub, r_rw, r_load, r_br;
    logic [4:0]  r_aa, r_ba, r_da;
    logic [31:0] r_bus_a, r_bus_b, r_ex_f, r_wb_d;
    int          r_dut;

    logic        w_stall0, w_bubble0, w_flush0, w_exv0, w_wbv0;
    logic [1:0]  w_sa0, w_sb0;
    logic [31:0] w_fa0, w_fb0;
    logic [15:0] w_cnt0;
    logic        w_stall1, w_bubble1, w_flush1, w_exv1, w_wbv1;
    logic [1:0]  w_sa1, w_sb1;
    logic [31:0] w_fa1, w_fb1;
    logic [1:0]  w_cnt1;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_exp[$];

    risc_pipe_hazard_ctrl #(.ADDR_W(5), .DATA_W(32), .FWD_EN(1), .CNT_W(16)) u_dut_fwd (
        .clk(clk), .reset(r_reset), .dof_valid(r_valid), .dof_aa(r_aa), .dof_ba(r_ba),
        .dof_use_a(r_ua), .dof_use_b(r_ub), .dof_rw(r_rw), .dof_da(r_da), .dof_load(r_load),
        .ex_branch_taken(r_br), .dof_bus_a(r_bus_a), .dof_bus_b(r_bus_b), .ex_f(r_ex_f),
        .wb_d(r_wb_d), .stall_if(w_stall0), .bubble_ex(w_bubble0), .flush_dof(w_flush0),
        .fwd_a_sel(w_sa0), .fwd_b_sel(w_sb0), .fwd_bus_a(w_fa0), .fwd_bus_b(w_fb0),
        .ex_valid(w_exv0), .wb_valid(w_wbv0), .stall_cnt(w_cnt0)
    );

    risc_pipe_hazard_ctrl #(.ADDR_W(5), .DATA_W(32), .FWD_EN(0), .CNT_W(2)) u_dut_stall (
        .clk(clk), .reset(r_reset), .dof_valid(r_valid), .dof_aa(r_aa), .dof_ba(r_ba),
        .dof_use_a(r_ua), .dof_use_b(r_ub), .dof_rw(r_rw), .dof_da(r_da), .dof_load(r_load),
        .ex_branch_taken(r_br), .dof_bus_a(r_bus_a), .dof_bus_b(r_bus_b), .ex_f(r_ex_f),
        .wb_d(r_wb_d), .stall_if(w_stall1), .bubble_ex(w_bubble1), .flush_dof(w_flush1),
        .fwd_a_sel(w_sa1), .fwd_b_sel(w_sb1), .fwd_bus_a(w_fa1), .fwd_bus_b(w_fb1),
        .ex_valid(w_exv1), .wb_valid(w_wbv1), .stall_cnt(w_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic v, input logic [4:0] aa, input logic [4:0] ba,
                                  input logic ua, input logic ub, input logic rw,
                                  input logic [4:0] da, input logic ld, input logic br);
        instr_t i;
        i = '{valid: v, aa: aa, ba: ba, ua: ua, ub: ub, rw: rw, da: da, load: ld, br: br};
        return i;
    endfunction

    function automatic exp_t ex(input logic st, input logic bu, input logic fl,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic ev, input logic wv, input logic [15:0] cnt);
        exp_t e;
        e = '{stall: st, bubble: bu, flush: fl, sa: sa, sb: sb, exv: ev, wbv: wv, cnt: cnt};
        return e;
    endfunction

    function automatic logic [31:0] exp_bus(input logic [1:0] sel, input logic [31:0] rf);
        case (sel)
            2'd1:    return c_EX_F;
            2'd2:    return c_WB_D;
            default: return rf;
        endcase
    endfunction

    // Compare one scoreboard entry against the selected instance
    task automatic compare_out(input string tag, input exp_t e);
        logic st, bu, fl, ev, wv;
        logic [1:0]  sa, sb;
        logic [31:0] fa, fb, cnt;
        if (r_dut == 0) begin
            st = w_stall0; bu = w_bubble0; fl = w_flush0; sa = w_sa0; sb = w_sb0;
            fa = w_fa0; fb = w_fb0; ev = w_exv0; wv = w_wbv0; cnt = 32'(w_cnt0);
        end else begin
            st = w_stall1; bu = w_bubble1; fl = w_flush1; sa = w_sa1; sb = w_sb1;
            fa = w_fa1; fb = w_fb1; ev = w_exv1; wv = w_wbv1; cnt = 32'(w_cnt1);
        end
        check_eq({tag, ".stall"},  32'(st), 32'(e.stall));
        check_eq({tag, ".bubble"}, 32'(bu), 32'(e.bubble));
        check_eq({tag, ".flush"},  32'(fl), 32'(e.flush));
        check_eq({tag, ".sel_a"},  32'(sa), 32'(e.sa));
        check_eq({tag, ".sel_b"},  32'(sb), 32'(e.sb));
        check_eq({tag, ".bus_a"},  fa, exp_bus(e.sa, c_BUS_A));
        check_eq({tag, ".bus_b"},  fb, exp_bus(e.sb, c_BUS_B));
        check_eq({tag, ".ex_valid"}, 32'(ev), 32'(e.exv));
        check_eq({tag, ".wb_valid"}, 32'(wv), 32'(e.wbv));
        check_eq({tag, ".cnt"},    cnt, 32'(e.cnt));
    endtask

    // Drive one DOF cycle, queue its expectation, check mid-cycle, advance edge
    task automatic step(input string tag, input instr_t i, input exp_t e);
        exp_t got;
        r_valid = i.valid; r_aa = i.aa; r_ba = i.ba; r_ua = i.ua; r_ub = i.ub;
        r_rw = i.rw; r_da = i.da; r_load = i.load; r_br = i.br;
        r_bus_a = c_BUS_A; r_bus_b = c_BUS_B; r_ex_f = c_EX_F; r_wb_d = c_WB_D;
        q_exp.push_back(e);
        @(posedge clk);
        got = q_exp.pop_front();
        compare_out(tag, got);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        r_reset = 1'b0;
        #1;
        r_reset = 1'b1;
    endtask

    initial begin
        r_dut = 0;
        r_reset = 1'b0;
        r_valid = 0; r_aa = 0; r_ba = 0; r_ua = 0; r_ub = 0; r_rw = 0; r_da = 0;
        r_load = 0; r_br = 0;
        r_bus_a = c_BUS_A; r_bus_b = c_BUS_B; r_ex_f = c_EX_F; r_wb_d = c_WB_D;

        // Reset held low with random stimulus: state stays empty
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            r_valid = 1'($urandom); r_aa = 5'($urandom); r_ba = 5'($urandom);
            r_ua = 1'($urandom); r_ub = 1'($urandom); r_rw = 1'($urandom);
            r_da = 5'($urandom); r_load = 1'($urandom); r_br = 1'($urandom);
            r_bus_a = $urandom; r_bus_b = $urandom; r_ex_f = $urandom; r_wb_d = $urandom;
            @(posedge clk);
            check_eq("rst.ex_valid0", 32'(w_exv0), 32'd0);
            check_eq("rst.wb_valid0", 32'(w_wbv0), 32'd0);
            check_eq("rst.cnt0",      32'(w_cnt0), 32'd0);
            check_eq("rst.stall0",    32'(w_stall0), 32'd0);
            check_eq("rst.sel_a0",    32'(w_sa0), 32'd0);
            check_eq("rst.bus_a0",    w_fa0, r_bus_a);
            check_eq("rst.ex_valid1", 32'(w_exv1), 32'd0);
            check_eq("rst.cnt1",      32'(w_cnt1), 32'd0);
            check_eq("rst.stall1",    32'(w_stall1), 32'd0);
        end
        @(negedge clk);
        #1;
        r_reset = 1'b1;

        // Forwarding instance: ALU chain, load-use, R0/no-use, branch priority
        r_dut = 0;
        step("A1.add_r3",  mk(1, 1, 2, 1, 1, 1, 3, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        step("A2.sub_r3",  mk(1, 3, 3, 1, 1, 1, 4, 0, 0), ex(0, 0, 0, 1, 1, 1, 0, 0));
        step("A3.rd_r3wb", mk(1, 3, 1, 1, 1, 1, 7, 0, 0), ex(0, 0, 0, 2, 0, 1, 1, 0));
        step("A4.ld_r5",   mk(1, 1, 0, 1, 0, 1, 5, 1, 0), ex(0, 0, 0, 0, 0, 1, 1, 0));
        step("A5.ld_use",  mk(1, 5, 1, 1, 1, 1, 6, 0, 0), ex(1, 1, 0, 0, 0, 1, 1, 0));
        step("A6.ld_fwd",  mk(1, 5, 1, 1, 1, 1, 6, 0, 0), ex(0, 0, 0, 2, 0, 0, 1, 1));
        step("A7.wr_r0",   mk(1, 1, 2, 1, 1, 1, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, 1));
        step("A8.rd_r0",   mk(1, 0, 0, 1, 1, 1, 2, 0, 0), ex(0, 0, 0, 0, 0, 1, 1, 1));
        step("A9.no_use",  mk(1, 1, 2, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 1, 1));
        step("A10.ld_r5",  mk(1, 1, 0, 1, 0, 1, 5, 1, 0), ex(0, 0, 0, 0, 0, 1, 1, 1));
        step("A11.br_win", mk(1, 5, 1, 1, 1, 1, 6, 0, 1), ex(0, 1, 1, 0, 0, 1, 1, 1));
        step("A12.post_br", mk(1, 5, 1, 1, 1, 1, 8, 0, 0), ex(0, 0, 0, 2, 0, 0, 1, 1));
        step("A13.inval",  mk(0, 8, 8, 1, 1, 1, 9, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, 1));
        step("A14.wb_r8",  mk(1, 8, 1, 1, 1, 0, 0, 0, 0), ex(0, 0, 0, 2, 0, 0, 1, 1));

        // Stall-only instance with a 2-bit counter: penalties and saturation
        pulse_reset();
        r_dut = 1;
        step("B1.add_r3",  mk(1, 1, 2, 1, 1, 1, 3, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        step("B2.ex_hit",  mk(1, 3, 1, 1, 1, 1, 4, 0, 0), ex(1, 1, 0, 0, 0, 1, 0, 0));
        step("B3.wb_hit",  mk(1, 3, 1, 1, 1, 1, 4, 0, 0), ex(1, 1, 0, 0, 0, 0, 1, 1));
        step("B4.go",      mk(1, 3, 1, 1, 1, 1, 4, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 2));
        step("B5.ex_hit",  mk(1, 4, 4, 1, 1, 1, 5, 0, 0), ex(1, 1, 0, 0, 0, 1, 0, 2));
        step("B6.wb_hit",  mk(1, 4, 4, 1, 1, 1, 5, 0, 0), ex(1, 1, 0, 0, 0, 0, 1, 3));
        step("B7.go",      mk(1, 4, 4, 1, 1, 1, 5, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 3));
        step("B8.sat_ex",  mk(1, 5, 1, 1, 1, 1, 6, 0, 0), ex(1, 1, 0, 0, 0, 1, 0, 3));
        step("B9.sat_wb",  mk(1, 5, 1, 1, 1, 1, 6, 0, 0), ex(1, 1, 0, 0, 0, 0, 1, 3));
        step("B10.go",     mk(1, 5, 1, 1, 1, 1, 6, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 3));

        // Mid-operation reset drops the in-flight writer
        pulse_reset();
        r_dut = 0;
        step("C1.add_r3",  mk(1, 1, 2, 1, 1, 1, 3, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));
        r_reset = 1'b0;
        #1;
        check_eq("C.async_ex_valid", 32'(w_exv0), 32'd0);
        r_reset = 1'b1;
        step("C2.after_rst", mk(1, 3, 3, 1, 1, 1, 4, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
